// File: rtl/mem_access_if.sv
// Data-memory bus between the memory-access stage and the data RAM.
// One req/gnt address phase, then an rvalid data phase for reads.
interface mem_access_if #(
  parameter int XLEN = 32
);
  logic            dmem_req_o;
  logic            dmem_we_o;
  logic [3:0]      dmem_be_o;
  logic [XLEN-1:0] dmem_addr_o;
  logic [XLEN-1:0] dmem_wdata_o;
  logic            dmem_gnt_i;
  logic            dmem_rvalid_i;
  logic [XLEN-1:0] dmem_rdata_i;

  modport master (
    output dmem_req_o, dmem_we_o, dmem_be_o,
    output dmem_addr_o, dmem_wdata_o,
    input  dmem_gnt_i, dmem_rvalid_i, dmem_rdata_i
  );

  modport slave (
    input  dmem_req_o, dmem_we_o, dmem_be_o,
    input  dmem_addr_o, dmem_wdata_o,
    output dmem_gnt_i, dmem_rvalid_i, dmem_rdata_i
  );
endinterface

// File: rtl/mem_access.sv
// Memory-access stage: one data-memory transaction at a time,
// store lane generation, load extraction and registered writeback.
module mem_access #(
  parameter int XLEN           = 32,
  parameter int SYS_REGS_WIDTH = 5
) (
  input  logic                      clk_i,
  input  logic                      resetn_i,
  input  logic [XLEN-1:0]           mem_addr_i,
  input  logic                      mem_read_en_i,
  input  logic                      mem_write_en_i,
  input  logic [2:0]                mem_write_fmt_i,
  input  logic [XLEN-1:0]           mem_write_data_i,
  input  logic [SYS_REGS_WIDTH-1:0] rd_addr_i,
  input  logic                      rd_write_en_i,
  input  logic [4:0]                rd_write_fmt_i,
  input  logic [XLEN-1:0]           rd_data_i,
  mem_access_if.master              dmem,
  output logic                      halt_o,
  output logic [SYS_REGS_WIDTH-1:0] wb_rd_addr_o,
  output logic                      wb_rd_write_en_o,
  output logic [XLEN-1:0]           wb_rd_data_o,
  output logic                      access_err_o
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT
  } state_t;

  state_t r_state, w_next;

  logic [XLEN-1:0]           r_addr;
  logic [1:0]                r_off;
  logic                      r_we;
  logic [3:0]                r_be;
  logic [XLEN-1:0]           r_wdata;
  logic [4:0]                r_lfmt;
  logic [SYS_REGS_WIDTH-1:0] r_rd;
  logic [SYS_REGS_WIDTH-1:0] r_wb_addr;
  logic                      r_wb_en;
  logic [XLEN-1:0]           r_wb_data;
  logic                      r_err;

  logic            w_rd, w_wr, w_any;
  logic            w_wfmt_ok, w_rfmt_ok;
  logic            w_byte, w_half, w_align;
  logic            w_ok, w_err, w_start;
  logic [3:0]      w_be;
  logic [XLEN-1:0] w_wdata;
  logic [7:0]      w_lbyte;
  logic [15:0]     w_lhalf;
  logic [XLEN-1:0] w_load;

  assign w_rd  = mem_read_en_i & ~mem_write_en_i;
  assign w_wr  = mem_write_en_i & ~mem_read_en_i;
  assign w_any = mem_read_en_i | mem_write_en_i;

  assign w_wfmt_ok = (mem_write_fmt_i != 3'b0) &&
    ((mem_write_fmt_i & (mem_write_fmt_i - 3'd1)) == 3'b0);
  assign w_rfmt_ok = (rd_write_fmt_i != 5'b0) &&
    ((rd_write_fmt_i & (rd_write_fmt_i - 5'd1)) == 5'b0);

  assign w_byte = w_rd ? (rd_write_fmt_i[0] | rd_write_fmt_i[3])
                       : mem_write_fmt_i[0];
  assign w_half = w_rd ? (rd_write_fmt_i[1] | rd_write_fmt_i[4])
                       : mem_write_fmt_i[1];

  assign w_align = w_byte
                 | (w_half & ~mem_addr_i[0])
                 | (~w_byte & ~w_half & (mem_addr_i[1:0] == 2'b00));

  assign w_ok    = ((w_rd & w_rfmt_ok) | (w_wr & w_wfmt_ok)) & w_align;
  assign w_err   = w_any & ~w_ok;
  assign w_start = (r_state == S_IDLE) & w_ok;

  always_comb begin
    w_be    = 4'b1111;
    w_wdata = mem_write_data_i;
    if (w_wr && w_wfmt_ok) begin
      unique case (1'b1)
        mem_write_fmt_i[0]: begin
          w_be    = 4'b0001 << mem_addr_i[1:0];
          w_wdata = {4{mem_write_data_i[7:0]}};
        end
        mem_write_fmt_i[1]: begin
          w_be    = mem_addr_i[1] ? 4'b1100 : 4'b0011;
          w_wdata = {2{mem_write_data_i[15:0]}};
        end
        default: begin
          w_be    = 4'b1111;
          w_wdata = mem_write_data_i;
        end
      endcase
    end
  end

  assign w_lbyte = dmem.dmem_rdata_i[8*r_off +: 8];
  assign w_lhalf = dmem.dmem_rdata_i[16*r_off[1] +: 16];

  always_comb begin
    w_load = dmem.dmem_rdata_i;
    unique case (1'b1)
      r_lfmt[0]: w_load = {{(XLEN-8){w_lbyte[7]}}, w_lbyte};
      r_lfmt[1]: w_load = {{(XLEN-16){w_lhalf[15]}}, w_lhalf};
      r_lfmt[2]: w_load = dmem.dmem_rdata_i;
      r_lfmt[3]: w_load = {{(XLEN-8){1'b0}}, w_lbyte};
      r_lfmt[4]: w_load = {{(XLEN-16){1'b0}}, w_lhalf};
      default:   w_load = dmem.dmem_rdata_i;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!resetn_i) r_state <= S_IDLE;
    else           r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: if (w_start) w_next = S_REQ;
      S_REQ:  if (dmem.dmem_gnt_i) w_next = r_we ? S_IDLE : S_WAIT;
      S_WAIT: if (dmem.dmem_rvalid_i) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Strobes default low so every event is exactly one cycle wide.
  always_ff @(posedge clk_i) begin
    if (!resetn_i) begin
      r_addr    <= '0;
      r_off     <= '0;
      r_we      <= 1'b0;
      r_be      <= '0;
      r_wdata   <= '0;
      r_lfmt    <= '0;
      r_rd      <= '0;
      r_wb_addr <= '0;
      r_wb_en   <= 1'b0;
      r_wb_data <= '0;
      r_err     <= 1'b0;
    end else begin
      r_wb_en <= 1'b0;
      r_err   <= 1'b0;
      if (r_state == S_IDLE) begin
        if (w_start) begin
          r_addr  <= {mem_addr_i[XLEN-1:2], 2'b00};
          r_off   <= mem_addr_i[1:0];
          r_we    <= w_wr;
          r_be    <= w_be;
          r_wdata <= w_wdata;
          r_lfmt  <= w_rd ? rd_write_fmt_i : 5'b00100;
          r_rd    <= rd_addr_i;
        end else if (w_err) begin
          r_err <= 1'b1;
        end else if (rd_write_en_i) begin
          r_wb_addr <= rd_addr_i;
          r_wb_data <= rd_data_i;
          r_wb_en   <= (rd_addr_i != '0);
        end
      end else if (r_state == S_WAIT && dmem.dmem_rvalid_i) begin
        r_wb_addr <= r_rd;
        r_wb_data <= w_load;
        r_wb_en   <= (r_rd != '0);
      end
    end
  end

  assign dmem.dmem_req_o   = (r_state == S_REQ);
  assign dmem.dmem_we_o    = r_we;
  assign dmem.dmem_be_o    = r_be;
  assign dmem.dmem_addr_o  = r_addr;
  assign dmem.dmem_wdata_o = r_wdata;

  assign halt_o           = (r_state != S_IDLE);
  assign wb_rd_addr_o     = r_wb_addr;
  assign wb_rd_write_en_o = r_wb_en;
  assign wb_rd_data_o     = r_wb_data;
  assign access_err_o     = r_err;

endmodule

// File: tb/tb_mem_access.sv
// Directed bench for mem_access: writeback, loads, stores,
// error pulses, x0 suppression and reset during a pending load.
module tb_mem_access;

  logic        clk;
  logic        resetn;
  logic [31:0] mem_addr;
  logic        mem_read_en;
  logic        mem_write_en;
  logic [2:0]  mem_write_fmt;
  logic [31:0] mem_write_data;
  logic [4:0]  rd_addr;
  logic        rd_write_en;
  logic [4:0]  rd_write_fmt;
  logic [31:0] rd_data;
  logic        halt;
  logic [4:0]  wb_rd_addr;
  logic        wb_rd_write_en;
  logic [31:0] wb_rd_data;
  logic        access_err;

  int errors = 0;
  int checks = 0;

  mem_access_if #(.XLEN(32)) bus ();

  mem_access #(.XLEN(32), .SYS_REGS_WIDTH(5)) dut (
    .clk_i            (clk),
    .resetn_i         (resetn),
    .mem_addr_i       (mem_addr),
    .mem_read_en_i    (mem_read_en),
    .mem_write_en_i   (mem_write_en),
    .mem_write_fmt_i  (mem_write_fmt),
    .mem_write_data_i (mem_write_data),
    .rd_addr_i        (rd_addr),
    .rd_write_en_i    (rd_write_en),
    .rd_write_fmt_i   (rd_write_fmt),
    .rd_data_i        (rd_data),
    .dmem             (bus),
    .halt_o           (halt),
    .wb_rd_addr_o     (wb_rd_addr),
    .wb_rd_write_en_o (wb_rd_write_en),
    .wb_rd_data_o     (wb_rd_data),
    .access_err_o     (access_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    mem_read_en    = 1'b0;
    mem_write_en   = 1'b0;
    rd_write_en    = 1'b0;
    mem_write_fmt  = 3'b000;
    rd_write_fmt   = 5'b00000;
  endtask

  initial begin
    resetn         = 1'b0;
    mem_addr       = '0;
    mem_write_data = '0;
    rd_addr        = '0;
    rd_data        = '0;
    idle_in();
    bus.dmem_gnt_i    = 1'b0;
    bus.dmem_rvalid_i = 1'b0;
    bus.dmem_rdata_i  = '0;
    step();
    step();
    chk("rst_req", 32'(bus.dmem_req_o), 32'd0);
    chk("rst_halt", 32'(halt), 32'd0);
    chk("rst_wb_en", 32'(wb_rd_write_en), 32'd0);
    chk("rst_err", 32'(access_err), 32'd0);
    chk("rst_addr", bus.dmem_addr_o, 32'd0);
    resetn = 1'b1;
    step();

    // ALU writeback
    rd_write_en = 1'b1;
    rd_addr     = 5'd5;
    rd_data     = 32'h1234;
    step();
    idle_in();
    chk("alu_wb_en", 32'(wb_rd_write_en), 32'd1);
    chk("alu_wb_addr", 32'(wb_rd_addr), 32'd5);
    chk("alu_wb_data", wb_rd_data, 32'h1234);
    chk("alu_halt", 32'(halt), 32'd0);
    step();
    chk("alu_wb_pulse", 32'(wb_rd_write_en), 32'd0);

    // LB sign-extend, grant with request
    mem_read_en  = 1'b1;
    mem_addr     = 32'h103;
    rd_write_fmt = 5'b00001;
    rd_addr      = 5'd7;
    step();
    idle_in();
    chk("lb_req", 32'(bus.dmem_req_o), 32'd1);
    chk("lb_addr", bus.dmem_addr_o, 32'h100);
    chk("lb_be", 32'(bus.dmem_be_o), 32'hF);
    chk("lb_we", 32'(bus.dmem_we_o), 32'd0);
    chk("lb_halt1", 32'(halt), 32'd1);
    bus.dmem_gnt_i = 1'b1;
    step();
    bus.dmem_gnt_i    = 1'b0;
    chk("lb_req_drop", 32'(bus.dmem_req_o), 32'd0);
    chk("lb_halt2", 32'(halt), 32'd1);
    chk("lb_wait_nowb", 32'(wb_rd_write_en), 32'd0);
    bus.dmem_rvalid_i = 1'b1;
    bus.dmem_rdata_i  = 32'h80FF_0000;
    step();
    bus.dmem_rvalid_i = 1'b0;
    chk("lb_halt_end", 32'(halt), 32'd0);
    chk("lb_wb_en", 32'(wb_rd_write_en), 32'd1);
    chk("lb_wb_addr", 32'(wb_rd_addr), 32'd7);
    chk("lb_wb_data", wb_rd_data, 32'hFFFF_FF80);
    step();
    chk("lb_wb_pulse", 32'(wb_rd_write_en), 32'd0);

    // LHU zero-extend, upper half
    mem_read_en  = 1'b1;
    mem_addr     = 32'h202;
    rd_write_fmt = 5'b10000;
    rd_addr      = 5'd8;
    step();
    idle_in();
    chk("lhu_addr", bus.dmem_addr_o, 32'h200);
    bus.dmem_gnt_i = 1'b1;
    step();
    bus.dmem_gnt_i    = 1'b0;
    bus.dmem_rvalid_i = 1'b1;
    bus.dmem_rdata_i  = 32'hBEEF_0000;
    step();
    bus.dmem_rvalid_i = 1'b0;
    chk("lhu_wb_en", 32'(wb_rd_write_en), 32'd1);
    chk("lhu_wb_data", wb_rd_data, 32'h0000_BEEF);

    // SB with grant on third request cycle
    mem_write_en   = 1'b1;
    mem_addr       = 32'h301;
    mem_write_fmt  = 3'b001;
    mem_write_data = 32'h0000_00AB;
    rd_addr        = 5'd3;
    step();
    idle_in();
    for (int i = 0; i < 3; i++) begin
      chk("sb_req", 32'(bus.dmem_req_o), 32'd1);
      chk("sb_we", 32'(bus.dmem_we_o), 32'd1);
      chk("sb_be", 32'(bus.dmem_be_o), 32'b0010);
      chk("sb_wdata", bus.dmem_wdata_o, 32'hABAB_ABAB);
      chk("sb_addr", bus.dmem_addr_o, 32'h300);
      chk("sb_halt", 32'(halt), 32'd1);
      bus.dmem_gnt_i = (i == 2);
      step();
    end
    bus.dmem_gnt_i = 1'b0;
    chk("sb_done_req", 32'(bus.dmem_req_o), 32'd0);
    chk("sb_done_halt", 32'(halt), 32'd0);
    chk("sb_no_wb", 32'(wb_rd_write_en), 32'd0);

    // SH upper half lanes
    mem_write_en   = 1'b1;
    mem_addr       = 32'h312;
    mem_write_fmt  = 3'b010;
    mem_write_data = 32'h5555_C0DE;
    step();
    idle_in();
    chk("sh_be", 32'(bus.dmem_be_o), 32'b1100);
    chk("sh_wdata", bus.dmem_wdata_o, 32'hC0DE_C0DE);
    bus.dmem_gnt_i = 1'b1;
    step();
    bus.dmem_gnt_i = 1'b0;
    chk("sh_done_halt", 32'(halt), 32'd0);

    // Misaligned LW
    mem_read_en  = 1'b1;
    mem_addr     = 32'h402;
    rd_write_fmt = 5'b00100;
    rd_addr      = 5'd4;
    step();
    idle_in();
    chk("mis_err", 32'(access_err), 32'd1);
    chk("mis_req", 32'(bus.dmem_req_o), 32'd0);
    chk("mis_halt", 32'(halt), 32'd0);
    step();
    chk("mis_err_pulse", 32'(access_err), 32'd0);
    chk("mis_req2", 32'(bus.dmem_req_o), 32'd0);

    // Read and write together
    mem_read_en   = 1'b1;
    mem_write_en  = 1'b1;
    mem_addr      = 32'h400;
    rd_write_fmt  = 5'b00100;
    mem_write_fmt = 3'b100;
    step();
    idle_in();
    chk("rw_err", 32'(access_err), 32'd1);
    chk("rw_req", 32'(bus.dmem_req_o), 32'd0);
    chk("rw_halt", 32'(halt), 32'd0);
    step();
    chk("rw_err_pulse", 32'(access_err), 32'd0);

    // LW to x0: bus read happens, writeback suppressed
    mem_read_en  = 1'b1;
    mem_addr     = 32'h500;
    rd_write_fmt = 5'b00100;
    rd_addr      = 5'd0;
    step();
    idle_in();
    chk("x0_req", 32'(bus.dmem_req_o), 32'd1);
    chk("x0_addr", bus.dmem_addr_o, 32'h500);
    bus.dmem_gnt_i = 1'b1;
    step();
    bus.dmem_gnt_i    = 1'b0;
    bus.dmem_rvalid_i = 1'b1;
    bus.dmem_rdata_i  = 32'hDEAD_BEEF;
    step();
    bus.dmem_rvalid_i = 1'b0;
    chk("x0_wb_en", 32'(wb_rd_write_en), 32'd0);
    chk("x0_wb_data", wb_rd_data, 32'hDEAD_BEEF);

    // Reset while waiting for read data
    mem_read_en  = 1'b1;
    mem_addr     = 32'h600;
    rd_write_fmt = 5'b00100;
    rd_addr      = 5'd9;
    step();
    idle_in();
    bus.dmem_gnt_i = 1'b1;
    step();
    bus.dmem_gnt_i = 1'b0;
    chk("rw8_halt", 32'(halt), 32'd1);
    resetn = 1'b0;
    step();
    resetn = 1'b1;
    bus.dmem_rvalid_i = 1'b1;
    bus.dmem_rdata_i  = 32'h1111_2222;
    chk("rstw_halt", 32'(halt), 32'd0);
    chk("rstw_req", 32'(bus.dmem_req_o), 32'd0);
    chk("rstw_addr", bus.dmem_addr_o, 32'd0);
    chk("rstw_be", 32'(bus.dmem_be_o), 32'd0);
    step();
    bus.dmem_rvalid_i = 1'b0;
    chk("rstw_no_wb", 32'(wb_rd_write_en), 32'd0);

    // Normal LW after reset
    mem_read_en  = 1'b1;
    mem_addr     = 32'h604;
    rd_write_fmt = 5'b00100;
    rd_addr      = 5'd10;
    step();
    idle_in();
    chk("post_req", 32'(bus.dmem_req_o), 32'd1);
    chk("post_addr", bus.dmem_addr_o, 32'h604);
    bus.dmem_gnt_i = 1'b1;
    step();
    bus.dmem_gnt_i    = 1'b0;
    bus.dmem_rvalid_i = 1'b1;
    bus.dmem_rdata_i  = 32'hCAFE_F00D;
    step();
    bus.dmem_rvalid_i = 1'b0;
    chk("post_wb_en", 32'(wb_rd_write_en), 32'd1);
    chk("post_wb_addr", 32'(wb_rd_addr), 32'd10);
    chk("post_wb_data", wb_rd_data, 32'hCAFE_F00D);
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_access.md
# mem_access

Memory-access stage of the RISC-V pipeline. It takes the registered load/store and writeback controls from the execute stage and runs one data-memory transaction at a time on a req/gnt/rvalid bus. For stores it generates byte lanes. For loads it extracts and sign- or zero-extends the result. It presents a registered writeback to the register file and drives `halt_o` back to the pipeline while a transaction is in flight.

## Interface
- `XLEN`, 32, datapath width (only 32 is supported)
- `SYS_REGS_WIDTH`, 5, register address width
- `clk_i  in  1  system clock`
- `resetn_i  in  1  reset; one clock, synchronous active-low reset`
- `mem_addr_i  in  XLEN  byte address from execute`
- `mem_read_en_i  in  1  load request`
- `mem_write_en_i  in  1  store request`
- `mem_write_fmt_i  in  3  store width, one-hot: [0] SB, [1] SH, [2] SW`
- `mem_write_data_i  in  XLEN  store data, right-aligned`
- `rd_addr_i  in  SYS_REGS_WIDTH  destination register`
- `rd_write_en_i  in  1  non-memory writeback request`
- `rd_write_fmt_i  in  5  load format, one-hot: [0] LB, [1] LH, [2] LW, [3] LBU, [4] LHU`
- `rd_data_i  in  XLEN  ALU/link result`
- `dmem_req_o  out  1  bus request`
- `dmem_we_o  out  1  1 = write`
- `dmem_be_o  out  4  byte enables`
- `dmem_addr_o  out  XLEN  word address, bits [1:0] = 0`
- `dmem_wdata_o  out  XLEN  lane-replicated store data`
- `dmem_gnt_i  in  1  request accepted`
- `dmem_rvalid_i  in  1  read data valid`
- `dmem_rdata_i  in  XLEN  read data`
- `halt_o  out  1  pipeline stall`
- `wb_rd_addr_o  out  SYS_REGS_WIDTH  writeback register`
- `wb_rd_write_en_o  out  1  writeback strobe`
- `wb_rd_data_o  out  XLEN  writeback data`
- `access_err_o  out  1  one-cycle pulse on a misaligned or illegal access`

## Operation
- **States:** IDLE, REQ, WAIT.
- **Input sampling:** inputs are sampled only in IDLE; every input is ignored in REQ and WAIT.
- **IDLE, read xor write enabled, one-hot fmt, aligned:**
  - Latch address, format, data and `rd_addr_i`.
  - Go to REQ.
- **Alignment rules:** halfword accesses need `addr[0]=0`; word accesses need `addr[1:0]=0`. Byte accesses are always aligned.
- **Errors:** an access is an error if it is misaligned, if read and write are both enabled, or if the relevant fmt is zero or multi-hot. On an error:
  - Pulse `access_err_o` next cycle.
  - No bus access and no writeback.
  - Stay in IDLE.
- **IDLE, `rd_write_en_i` with no memory enable:** next cycle `wb_rd_write_en_o=1` with `rd_addr_i`/`rd_data_i`.
- **REQ:**
  - `dmem_req_o=1`; address, `we`, `be` and `wdata` are held stable until `dmem_gnt_i`.
  - On grant, a store goes to IDLE and a load goes to WAIT.
- **WAIT:**
  - `dmem_rvalid_i` is sampled only in WAIT.
  - On `rvalid`, register the formatted data, pulse `wb_rd_write_en_o`, and go to IDLE.
- **Store lanes:**
  - SB: `be = 1<<addr[1:0]`, `wdata = {4{d[7:0]}}`.
  - SH: `be = addr[1] ? 1100 : 0011`, `wdata = {2{d[15:0]}}`.
  - SW: `be = 1111`, `wdata = d`.
- **Load extract:**
  - The selected byte is `rdata[8*addr[1:0] +: 8]`; the selected half is `rdata[16*addr[1] +: 16]`.
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
- **x0 suppression:** `wb_rd_write_en_o` is forced to 0 when the writeback register is 0; data is still registered.
- **Halt:** `halt_o = (state != IDLE)`.

## Timing
- **Reset values:** reset forces state IDLE. Every output resets to 0: `dmem_req_o`, `dmem_we_o`, `dmem_be_o`, `dmem_addr_o`, `dmem_wdata_o`, `halt_o`, all `wb_*`, `access_err_o`.
- **Reset mid-transaction:** `dmem_req_o` drops the cycle after reset is sampled, and any pending load is discarded with no writeback.
- **Non-memory writeback:** latency 1 cycle.
- **Load accepted at cycle T, gnt at T+k (k≥1), rvalid at T+m (m>k):**
  - `req` is high T+1..T+k.
  - `wb_rd_write_en_o` is high at T+m+1.
  - `halt_o` is high T+1..T+m and low at T+m+1.
- **Store accepted at T, gnt at T+k:** `halt_o` is high T+1..T+k; IDLE at T+k+1.
- **Error accepted at T:** `access_err_o` is high at T+1 only; `halt_o` stays 0.
- **Back-to-back:** a new request can be accepted in the cycle the FSM returns to IDLE.
- **Single-cycle pulses:** `wb_rd_write_en_o` and `access_err_o` are high for exactly one cycle per event.

## Test plan
- **ALU writeback:** `rd_write_en_i=1`, `rd=5`, data `0x1234`. Expect `wb_*` = (5, `0x1234`, en=1) one cycle later; `halt_o` stays 0.
- **LB sign-extend:** LB at `0x103`, gnt same cycle as req, rvalid one cycle later with `rdata=0x80FF_0000`. Expect `dmem_addr_o=0x100`, `be=1111`, `we=0`; wb data `0xFFFF_FF80`; `halt_o` high for 2 cycles.
- **LHU zero-extend:** LHU at `0x202`, `rdata=0xBEEF_0000`. Expect wb data `0x0000_BEEF`.
- **SB with delayed grant:** SB at `0x301`, data `0xAB`, gnt after 3 cycles. Expect `req` high with stable `be=0010`, `wdata=0xABAB_ABAB` for 3 cycles; no writeback; `halt_o` high for 3 cycles.
- **Error cases:**
  - LW at `0x402` → `access_err_o` one pulse, no `req`.
  - Read and write both enabled → same.
  - LW with `rd=0` → bus read occurs, `wb_rd_write_en_o` stays 0.
- **Reset in WAIT:** assert `resetn_i=0` while in WAIT, then send rvalid. Expect no writeback, all outputs 0, state IDLE, and the next access proceeds normally.
